// File: rtl/sum_adder_driver.sv
// rtl/sum_adder_driver.sv - initiator that launches a sum(1..N) adder and returns its result
// Optional build macro SUMDRV_CHECK_EN: verify the captured sum against n*(n+1)/2 before responding.
module sum_adder_driver #(
    parameter int N_WIDTH        = 8,
    parameter int SUM_WIDTH      = 16,
    parameter int START_HOLD     = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [N_WIDTH-1:0]   req_n,
    output logic                 sa_start,
    output logic [N_WIDTH-1:0]   sa_inBus,
    input  logic                 sa_done,
    input  logic [SUM_WIDTH-1:0] sa_sum,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N_WIDTH-1:0]   rsp_n,
    output logic [SUM_WIDTH-1:0] rsp_sum,
    output logic                 rsp_timeout,
    output logic                 rsp_mismatch,
    output logic                 busy
);

    localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        CHECK  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t         state;
    state_t         stateNext;
    logic [HW-1:0]  holdCnt;
    logic [TW-1:0]  toCnt;
    logic [N_WIDTH-1:0] nReg;
    logic           armed;
    logic           accept;
    logic           capture;
    logic           timeoutHit;
    logic           holdDone;

    assign req_ready  = (state == IDLE);
    assign accept     = (state == IDLE) && req_valid;
    assign holdDone   = (holdCnt == HW'(START_HOLD - 1));
    // A done level seen before the adder dropped it for this launch is stale.
    assign capture    = (state == WAIT) && armed && sa_done;
    assign timeoutHit = (state == WAIT) && !capture && (toCnt == TW'(TIMEOUT_CYCLES - 1));
    assign sa_inBus   = nReg;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:   if (req_valid) stateNext = LAUNCH;
            LAUNCH: if (holdDone) stateNext = WAIT;
            WAIT: begin
                if (capture) begin
`ifdef SUMDRV_CHECK_EN
                    stateNext = CHECK;
`else
                    stateNext = RESP;
`endif
                end else if (timeoutHit) begin
                    stateNext = RESP;
                end
            end
            CHECK:  stateNext = RESP;
            RESP:   if (rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sa_start  <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            holdCnt   <= '0;
            toCnt     <= '0;
            nReg      <= '0;
            armed     <= 1'b0;
        end else begin
            state     <= stateNext;
            sa_start  <= (stateNext == LAUNCH);
            busy      <= (stateNext != IDLE);
            rsp_valid <= (stateNext == RESP);
            holdCnt   <= (state == LAUNCH) ? holdCnt + HW'(1) : '0;
            toCnt     <= (state == WAIT) ? toCnt + TW'(1) : '0;
            if (accept) begin
                nReg  <= req_n;
                armed <= 1'b0;
            end else if (((state == LAUNCH) || (state == WAIT)) && !sa_done) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_n       <= '0;
            rsp_sum     <= '0;
            rsp_timeout <= 1'b0;
        end else if (capture) begin
            rsp_n       <= nReg;
            rsp_sum     <= sa_sum;
            rsp_timeout <= 1'b0;
        end else if (timeoutHit) begin
            rsp_n       <= nReg;
            rsp_sum     <= '0;
            rsp_timeout <= 1'b1;
        end
    end

`ifdef SUMDRV_CHECK_EN
    localparam int PW = 2 * N_WIDTH + 1;

    logic [PW-1:0]        prodFull;
    logic [SUM_WIDTH-1:0] expSum;
    logic                 mismatchReg;

    always_comb begin
        prodFull = PW'(nReg) * (PW'(nReg) + PW'(1));
        expSum   = SUM_WIDTH'(prodFull >> 1);
    end

    // The product is formed in CHECK against the sum already captured into rsp_sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatchReg <= 1'b0;
        end else if (capture || timeoutHit) begin
            mismatchReg <= 1'b0;
        end else if (state == CHECK) begin
            mismatchReg <= (expSum != rsp_sum);
        end
    end

    assign rsp_mismatch = mismatchReg;
`else
    assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_sum_adder_driver.sv
// tb/tb_sum_adder_driver.sv - randomized self-checking bench for sum_adder_driver
`timescale 1ns/1ps
module tb_sum_adder_driver;

    localparam int NW = 8;
    localparam int SW = 16;
    localparam int SH = 2;
    localparam int TO = 40;
`ifdef SUMDRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [NW-1:0] req_n = '0;
    logic          sa_start;
    logic [NW-1:0] sa_inBus;
    logic          sa_done = 1'b0;
    logic [SW-1:0] sa_sum = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [NW-1:0] rsp_n;
    logic [SW-1:0] rsp_sum;
    logic          rsp_timeout;
    logic          rsp_mismatch;
    logic          busy;

    always #5 clk = ~clk;

    sum_adder_driver #(
        .N_WIDTH(NW), .SUM_WIDTH(SW), .START_HOLD(SH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
        .sa_start(sa_start), .sa_inBus(sa_inBus), .sa_done(sa_done), .sa_sum(sa_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_n(rsp_n), .rsp_sum(rsp_sum),
        .rsp_timeout(rsp_timeout), .rsp_mismatch(rsp_mismatch), .busy(busy)
    );

    int nTests = 0;
    int nFail  = 0;
    bit chkOn  = 1'b0;

    logic          expReqReady = 1'b1, expStart = 1'b0, expBusy = 1'b0, expRspValid = 1'b0;
    logic [NW-1:0] expN = '0;
    logic [SW-1:0] expSum = '0;
    logic          expTo = 1'b0, expMis = 1'b0;
    logic [SW-1:0] lastSum;
    logic          lastTo, lastMis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] triSum(input int n);
        int s = 0;
        for (int i = 1; i <= n; i++) s += i;
        return SW'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setExp(input bit rdy, input bit st, input bit bz, input bit rv);
        expReqReady = rdy; expStart = st; expBusy = bz; expRspValid = rv;
    endtask

    always @(negedge clk) begin
        if (chkOn) begin
            check("req_ready", req_ready, expReqReady);
            check("sa_start", sa_start, expStart);
            check("busy", busy, expBusy);
            check("rsp_valid", rsp_valid, expRspValid);
            if (expBusy) check("sa_inBus", sa_inBus, expN);
            if (expRspValid) begin
                check("rsp_n", rsp_n, expN);
                check("rsp_sum", rsp_sum, expSum);
                check("rsp_timeout", rsp_timeout, expTo);
                check("rsp_mismatch", rsp_mismatch, expMis);
            end
        end
    end

    // mode 0: done rises at WAIT cycle d; 1: done stuck high; 2: done never; 3: stale high, drops at WAIT 1, rises at d
    task automatic runTxn(input int n, input int mode, input int d, input bit faulty, input int hold);
        logic [SW-1:0] sumVal;
        bit capOk;
        int capIdx;
        sumVal = faulty ? ((n == 10) ? SW'(100) : triSum(n) ^ SW'(16'h0101)) : triSum(n);
        sa_sum = sumVal;
        if (mode == 1 || mode == 2) capOk = 1'b0;
        else capOk = (d < TO);
        capIdx = capOk ? d : TO - 1;

        req_valid = 1'b1; req_n = NW'(n); setExp(1, 0, 0, 0);
        step();
        expN = NW'(n);
        for (int i = 0; i < SH; i++) begin
            req_valid = 1'($urandom); req_n = NW'($urandom);
            sa_done = (mode == 1 || mode == 3);
            setExp(0, 1, 1, 0);
            step();
        end
        for (int w = 0; w <= capIdx; w++) begin
            case (mode)
                0: sa_done = (w >= d);
                1: sa_done = 1'b1;
                2: sa_done = 1'b0;
                default: sa_done = (w == 0) || (w >= d);
            endcase
            req_valid = 1'($urandom); req_n = NW'($urandom);
            setExp(0, 0, 1, 0);
            step();
        end
        if (CHK && capOk) begin
            setExp(0, 0, 1, 0);
            step();
        end
        expSum = capOk ? sumVal : '0;
        expTo  = !capOk;
        expMis = CHK && capOk && (sumVal != triSum(n));
        for (int h = 0; h <= hold; h++) begin
            rsp_ready = (h == hold);
            req_valid = 1'($urandom); req_n = NW'($urandom);
            setExp(0, 0, 1, 1);
            lastSum = rsp_sum; lastTo = rsp_timeout; lastMis = rsp_mismatch;
            step();
        end
        rsp_ready = 1'b0; req_valid = 1'b0;
        setExp(1, 0, 0, 0);
    endtask

    task automatic midReset(input int n, input int k);
        req_valid = 1'b1; req_n = NW'(n); setExp(1, 0, 0, 0);
        step();
        req_valid = 1'b0; expN = NW'(n); sa_done = 1'b0;
        for (int i = 0; i < k; i++) begin
            setExp(0, (i < SH), 1, 0);
            step();
        end
        check("busy_before_rst", busy, 1);
        check("start_before_rst", sa_start, (k < SH));
        #1 rst = 1'b0;
        #1;
        check("rst_sa_start", sa_start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_sa_inBus", sa_inBus, 0);
        setExp(1, 0, 0, 0);
        step();
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, d, n;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", req_ready, 1);
        check("reset_sa_start", sa_start, 0);
        check("reset_sa_inBus", sa_inBus, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_sum", rsp_sum, 0);
        check("reset_rsp_timeout", rsp_timeout, 0);
        check("reset_rsp_mismatch", rsp_mismatch, 0);
        check("reset_busy", busy, 0);
        rst = 1'b1;
        setExp(1, 0, 0, 0);
        chkOn = 1'b1;
        step();

        runTxn(16, 0, 20, 0, 0);
        check("pin_sum16", lastSum, 136);
        check("pin_to16", lastTo, 0);
        check("pin_mis16", lastMis, 0);
        runTxn(255, 0, 5, 0, 0);
        check("pin_sum255", lastSum, 32640);
        runTxn(0, 0, 3, 0, 0);
        check("pin_sum0", lastSum, 0);
        runTxn(33, 0, 4, 0, 10);
        runTxn(7, 1, 0, 0, 0);
        check("pin_stale_to", lastTo, 1);
        check("pin_stale_sum", lastSum, 0);
        runTxn(9, 2, TO + 5, 0, 0);
        check("pin_never_to", lastTo, 1);
        runTxn(12, 0, TO - 1, 0, 0);
        check("pin_edge_capture", lastTo, 0);
        check("pin_edge_sum", lastSum, 78);
        runTxn(12, 0, TO, 0, 0);
        check("pin_edge_timeout", lastTo, 1);
        runTxn(20, 3, 6, 0, 2);

        midReset(20, 1);
        midReset(40, SH + 3);
        runTxn(5, 0, 2, 0, 0);
        check("pin_sum5", lastSum, 15);

        runTxn(10, 0, 6, 1, 0);
        check("pin_faulty_sum", lastSum, 100);
        check("pin_faulty_mis", lastMis, CHK);

        for (int t = 0; t < 40; t++) begin
            n    = $urandom_range(0, 255);
            mode = $urandom_range(0, 3);
            d    = (mode == 3) ? $urandom_range(2, TO + 3) : $urandom_range(0, TO + 3);
            runTxn(n, mode, d, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 5));
        end

        step();
        chkOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/sum_adder_driver.md
Name: sum_adder_driver

Overview:
- Initiator-side companion for the sum-adder block, which computes sum(1..N).
- Accepts N requests from a host over a valid/ready handshake and drives the sum adder's start/data inputs.
- Waits for the adder's done, captures the 16-bit sum, and returns it to the host over a valid/ready response channel.
- Flags a timeout if done never arrives; sits between the host sequencer and the sum-adder instance.

Parameters:
- N_WIDTH, 8, width of N and of the data bus to the adder.
- SUM_WIDTH, 16, width of the sum returned by the adder.
- START_HOLD, 2, cycles sa_start is held high per launch (minimum 1).
- TIMEOUT_CYCLES, 1023, maximum cycles in WAIT before a timeout response.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  driver can accept a request.
- req_n  in  N_WIDTH  N to sum.
- sa_start  out  1  start pulse to the sum adder.
- sa_inBus  out  N_WIDTH  N presented to the sum adder.
- sa_done  in  1  done from the sum adder.
- sa_sum  in  SUM_WIDTH  sum from the sum adder.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_n  out  N_WIDTH  N of this response.
- rsp_sum  out  SUM_WIDTH  captured sum (0 on timeout).
- rsp_timeout  out  1  response is a timeout.
- rsp_mismatch  out  1  sum check failed (see Optional Feature).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - All outputs 0 except req_ready=1.
  - sa_inBus=0; internal counters cleared.
- State IDLE: req_ready=1.
  - On req_valid & req_ready, latch req_n into n_reg; go to LAUNCH the next cycle.
- State LAUNCH: sa_start=1 for exactly START_HOLD cycles (hold counter).
  - sa_inBus=n_reg; held stable from LAUNCH through WAIT.
  - Then go to WAIT with sa_start=0.
- Arming (done-edge qualification):
  - A done flag left over from a previous operation is never captured.
  - An internal armed bit clears on entering LAUNCH.
  - armed sets on any cycle in LAUNCH or WAIT where sa_done is sampled 0.
- State WAIT: capture condition is armed & sa_done.
  - On capture, register rsp_sum=sa_sum, rsp_n=n_reg, rsp_timeout=0; go to RESP.
  - The timeout counter increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES before capture: rsp_sum=0, rsp_timeout=1, rsp_n=n_reg; go to RESP.
  - If capture and timeout occur in the same cycle, capture wins.
- State RESP: rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE; rsp_valid drops the next cycle.
  - req_ready=0 in RESP: no overlap, one request outstanding.
- Latency, request accept to rsp_valid: 1 + START_HOLD + (cycles to armed done) + 1.
- req_ready is 0 in LAUNCH, WAIT and RESP; req_valid is ignored there.
- N=0 is legal and forwarded unchanged; no special-casing.
- Reset mid-operation returns to IDLE immediately; any in-flight result is discarded; sa_start drops asynchronously.
- All outputs are registered; no combinational path from inputs to outputs except req_ready, which is decoded from state only.

Optional Feature:
- Macro: SUMDRV_CHECK_EN.
- Defined: on capture, compute the expected value n_reg*(n_reg+1)/2 at SUM_WIDTH width (a one-cycle registered multiply is allowed, with RESP entered one cycle later).
  - Set rsp_mismatch=1 if it differs from the captured sa_sum.
  - rsp_mismatch is always 0 on a timeout.
- Not defined: rsp_mismatch tied to 0, no multiplier synthesized, no extra latency.

Test Plan:
1. Reset, then req_n=16 with a correct adder model (done after 20 cycles) -> sa_start high 2 cycles, sa_inBus=16; rsp_sum=136, rsp_timeout=0, rsp_mismatch=0.
2. req_n=255 and req_n=0 back to back -> rsp_sum=32640, then rsp_sum=0; req_ready=0 between request accept and response handshake.
3. rsp_ready held low 10 cycles after rsp_valid -> rsp_n/rsp_sum stable; return to IDLE only on the handshake; a second req_valid during this time is not accepted.
4. Adder model holds sa_done=1 from the previous op and never drops it, or never asserts it -> after TIMEOUT_CYCLES, rsp_timeout=1, rsp_sum=0.
5. Assert rst=0 asynchronously mid-WAIT -> sa_start=0, rsp_valid=0, req_ready=1 immediately; a new req_n=5 then yields rsp_sum=15.
6. With SUMDRV_CHECK_EN, faulty model returns 100 for N=10 -> rsp_sum=100, rsp_mismatch=1; without the macro, rsp_mismatch=0.
